// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings and DMA state type shared by the DMA master and its neighbours.
package ahb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HSIZE_WORD      = 3'b010;
    localparam logic [2:0] HBURST_SINGLE   = 3'b000;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, FINISH} dma_state_t;
endpackage

// File: rtl/ahb_dma_master.sv
// ahb_dma_master: single-channel AHB-Lite DMA copying 32-bit words via SINGLE read/write transfers.
// Define AHB_DMA_ABORT_EN to add the abort input and the sticky aborted output.
module ahb_dma_master
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [LEN_WIDTH-1:0]  words_done,
`ifdef AHB_DMA_ABORT_EN
    input  logic                  abort,
    output logic                  aborted,
`endif
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic                  HWRITE,
    output logic [DATA_WIDTH-1:0] HWDATA,
    output logic [1:0]            HTRANS,
    output logic [2:0]            HSIZE,
    output logic [3:0]            HPROT,
    output logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);
    dma_state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
    logic [LEN_WIDTH-1:0] len_q, len_d, cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic err_q, err_d, done_q, done_d;
    logic abt;
`ifdef AHB_DMA_ABORT_EN
    logic aborted_q, aborted_d;
    // aborted_q doubles as the pending-abort flag so an abort seen mid data phase is honoured at its end
    assign aborted_d = (state_q == IDLE && start) ? 1'b0 : aborted_q | (busy & abort);
    assign abt = abort | aborted_q;
    assign aborted = aborted_q;
    always_ff @(posedge clk) aborted_q <= rst ? 1'b0 : aborted_d;
`else
    assign abt = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        done_d  = state_q == FINISH;
        case (state_q)
            IDLE: if (start) begin
                src_d   = src_addr & ~ADDR_WIDTH'(3);
                dst_d   = dst_addr & ~ADDR_WIDTH'(3);
                len_d   = len;
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = (len == '0) ? FINISH : RD_ADDR;
            end
            RD_ADDR: state_d = abt ? FINISH : HREADY ? RD_DATA : RD_ADDR;
            RD_DATA: if (HRESP) begin
                err_d   = 1'b1;
                state_d = FINISH;
            end else if (HREADY) begin
                data_d  = HRDATA;
                state_d = abt ? FINISH : WR_ADDR;
            end
            WR_ADDR: state_d = abt ? FINISH : HREADY ? WR_DATA : WR_ADDR;
            WR_DATA: if (HRESP) begin
                err_d   = 1'b1;
                state_d = FINISH;
            end else if (HREADY) begin
                cnt_d   = cnt_q + LEN_WIDTH'(1);
                src_d   = src_q + ADDR_WIDTH'(4);
                dst_d   = dst_q + ADDR_WIDTH'(4);
                state_d = (cnt_d == len_q || abt) ? FINISH : RD_ADDR;
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        HTRANS = (state_q == RD_ADDR || state_q == WR_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        HWRITE = state_q == WR_ADDR;
        HADDR  = (state_q == WR_ADDR) ? dst_q : (state_q == RD_ADDR) ? src_q : '0;
        busy   = !(state_q == IDLE || state_q == FINISH);
    end
    assign HWDATA     = data_q;
    assign HSIZE      = HSIZE_WORD;
    assign HPROT      = HPROT_DATA_PRIV;
    assign HBURST     = HBURST_SINGLE;
    assign done       = done_q;
    assign error      = err_q;
    assign words_done = cnt_q;
endmodule

// File: tb/tb_ahb_dma_master.sv
// tb_ahb_dma_master: scoreboard bench with a reactive zero/wait/error AHB slave model.
module tb_ahb_dma_master;
    logic clk = 1'b0;
    logic rst, start, busy, done, error, HWRITE, HREADY, HRESP;
    logic [31:0] src_addr, dst_addr, HADDR, HWDATA, HRDATA;
    logic [15:0] len, words_done;
    logic [1:0] HTRANS;
    logic [2:0] HSIZE, HBURST;
    logic [3:0] HPROT;
`ifdef AHB_DMA_ABORT_EN
    logic abort = 1'b0;
    logic aborted;
`endif
    int n_vec = 0, n_bad = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_rd [$];
    logic [63:0] exp_wr [$];
    logic ph_v = 1'b0, ph_w = 1'b0, ph_e = 1'b0;
    logic [31:0] ph_a = '0;
    int wl = 0, est = 0, waits = 0, err_wr = 0, wr_seen = 0, ns_cnt = 0, done_cnt = 0;

    always #5 clk = ~clk;

    ahb_dma_master dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .error(error), .words_done(words_done),
`ifdef AHB_DMA_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .HADDR(HADDR), .HWRITE(HWRITE), .HWDATA(HWDATA), .HTRANS(HTRANS), .HSIZE(HSIZE),
        .HPROT(HPROT), .HBURST(HBURST), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : pat(a);
    endfunction

    task automatic expect_copy(input logic [31:0] s, input logic [31:0] d, input int nr, input int nw);
        logic [31:0] sa, da;
        sa = s & ~32'd3;
        da = d & ~32'd3;
        for (int i = 0; i < nr; i++) exp_rd.push_back(sa + 32'(4 * i));
        for (int i = 0; i < nw; i++) exp_wr.push_back({da + 32'(4 * i), rd_val(sa + 32'(4 * i))});
    endtask

    task automatic drained();
        chk("rd_left", exp_rd.size(), 0);
        chk("wr_left", exp_wr.size(), 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                       input int ign, output int cyc);
        @(posedge clk); #1;
        src_addr = s; dst_addr = d; len = n; start = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            start = (k == ign);
            if (k == ign) begin
                src_addr = 32'hA00; dst_addr = 32'hB00; len = 16'd1;
            end
            if (k == 1) chk("busy_c1", busy, n != 0);
            if (done) begin
                cyc = k;
                break;
            end
        end
        chk("done_seen", done, 1);
    endtask

    // Slave: samples the bus at the edge, drives its response 1 time unit later.
    always @(posedge clk) begin
        logic [63:0] e;
        logic [31:0] ra;
        if (done) done_cnt++;
        if (rst) ph_v = 1'b0;
        else begin
            if (ph_v && !HREADY && ph_w && !ph_e && exp_wr.size() > 0)
                chk("hwdata_wait", HWDATA, exp_wr[0][31:0]);
            if (ph_v && HREADY) begin
                if (ph_w && !HRESP) begin
                    e = exp_wr.size() > 0 ? exp_wr.pop_front() : 64'hBAD0_BAD0_BAD0_BAD0;
                    chk("wr_addr", ph_a, e[63:32]);
                    chk("wr_data", HWDATA, e[31:0]);
                    mem[ph_a] = HWDATA;
                end
                ph_v = 1'b0;
            end
            if (HREADY && HTRANS == 2'b10) begin
                ns_cnt++;
                ph_v = 1'b1; ph_a = HADDR; ph_w = HWRITE; wl = waits; est = 0;
                if (HWRITE) wr_seen++;
                ph_e = HWRITE && wr_seen == err_wr;
                if (!HWRITE) begin
                    ra = exp_rd.size() > 0 ? exp_rd.pop_front() : 32'hBAD0_BAD0;
                    chk("rd_addr", HADDR, ra);
                end
            end
        end
        #1;
        HRESP = 1'b0; HREADY = 1'b1; HRDATA = '0;
        if (ph_v) begin
            if (ph_e) begin
                HRESP = 1'b1; HREADY = est == 1; est = 1;
            end else if (wl > 0) begin
                HREADY = 1'b0; wl--;
            end else if (!ph_w) HRDATA = rd_val(ph_a);
        end
    end

    initial begin
        int c, ns0, d0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        idle(3);
        chk("rst_htrans", HTRANS, 0);
        chk("rst_haddr", HADDR, 0);
        chk("rst_hwrite", HWRITE, 0);
        chk("rst_hwdata", HWDATA, 0);
        chk("rst_flags", {busy, done, error}, 0);
        chk("rst_words", words_done, 0);
        chk("fixed_ctl", {HSIZE, HPROT, HBURST}, {3'b010, 4'b0011, 3'b000});
        rst = 1'b0;
        idle(2);
        // zero-wait copy
        expect_copy(32'h0, 32'h20, 3, 3);
        run(32'h0, 32'h20, 16'd3, 0, c);
        chk("zw_cycles", c, 14);
        chk("zw_words", words_done, 3);
        chk("zw_error", error, 0);
        drained();
        idle(2);
        // two wait states per data phase
        waits = 2;
        expect_copy(32'h100, 32'h200, 2, 2);
        run(32'h100, 32'h200, 16'd2, 0, c);
        chk("ws_cycles", c, 18);
        chk("ws_words", words_done, 2);
        drained();
        waits = 0;
        idle(2);
        // error on the second write
        err_wr = 2; wr_seen = 0; ns0 = ns_cnt; d0 = done_cnt;
        expect_copy(32'h300, 32'h400, 2, 1);
        run(32'h300, 32'h400, 16'd4, 0, c);
        idle(4);
        chk("er_error", error, 1);
        chk("er_words", words_done, 1);
        chk("er_xfers", ns_cnt - ns0, 4);
        chk("er_done_cnt", done_cnt - d0, 1);
        drained();
        err_wr = 0;
        // len=0: no bus traffic, error cleared
        ns0 = ns_cnt;
        run(32'h40, 32'h80, 16'd0, 0, c);
        chk("l0_cycles", c, 2);
        chk("l0_xfers", ns_cnt - ns0, 0);
        chk("l0_error", error, 0);
        chk("l0_words", words_done, 0);
        idle(2);
        // start while busy is ignored
        ns0 = ns_cnt;
        expect_copy(32'h500, 32'h600, 5, 5);
        run(32'h500, 32'h600, 16'd5, 5, c);
        chk("sb_cycles", c, 22);
        chk("sb_words", words_done, 5);
        idle(4);
        chk("sb_xfers", ns_cnt - ns0, 10);
        chk("sb_busy", busy, 0);
        drained();
        // reset during the first write data phase
        d0 = done_cnt;
        expect_copy(32'h700, 32'h800, 1, 0);
        @(posedge clk); #1;
        src_addr = 32'h700; dst_addr = 32'h800; len = 16'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idle(3);
        chk("rs_busy_pre", busy, 1);
        rst = 1'b1;
        idle(1);
        chk("rs_htrans", HTRANS, 0);
        chk("rs_out", {busy, done, error, HWRITE}, 0);
        chk("rs_haddr", HADDR, 0);
        chk("rs_hwdata", HWDATA, 0);
        chk("rs_words", words_done, 0);
        rst = 1'b0;
        idle(8);
        chk("rs_no_done", done_cnt - d0, 0);
        drained();
        // source wraps past the top of the address space, low bits ignored
        expect_copy(32'hFFFF_FFFF, 32'h903, 2, 2);
        run(32'hFFFF_FFFF, 32'h903, 16'd2, 0, c);
        chk("wr_words", words_done, 2);
        drained();
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
